// File: rtl/adder_pkg.sv
// Shared constants and stage control record for the pipelined lookahead adder.
// Latency: n/a (types only).
// Backpressure: n/a.
package adder_pkg;

  // Every pipeline stage resolves one lookahead slice of this many bits.
  localparam int SLICE_W = 4;

  // Width-independent part of a stage record. Operand and sum fields depend on
  // WIDTH, so the top module wraps this in its own local struct.
  typedef struct packed {
    logic valid;  // stage holds a live beat
    logic carry;  // carry out of the most recently resolved slice
    logic sub;    // beat was a subtraction (B already inverted at entry)
  } stage_ctl_t;

endpackage

// File: rtl/cla4_slice.sv
// Purpose: combinational 4-bit carry-lookahead slice with carry into bit 3 exposed.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the enclosing pipeline decides when results are captured.
module cla4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout,
  output logic       c3
);

  logic [3:0] g;
  logic [3:0] p;
  logic       c1;
  logic       c2;

  assign g = a & b;
  assign p = a ^ b;

  // Every carry is a flat generate/propagate product, so no carry ripples
  // inside the slice.
  assign c1   = g[0] | (p[0] & cin);
  assign c2   = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c3   = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign sum = p ^ {c3, c2, c1, cin};

endmodule

// File: rtl/pipelined_cla_adder.sv
// Purpose: WIDTH-bit add/subtract, one 4-bit lookahead slice per pipeline stage, with cout/ovf/zero flags.
// Latency: WIDTH/4 register stages; a beat accepted at edge t is presented after edge t+WIDTH/4-1.
// Backpressure: global stall; all stages hold while out_valid & ~out_ready, and in_ready mirrors the advance signal.
module pipelined_cla_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);

  // WIDTH must be a multiple of 4 and at least 4.
  localparam int NSLICE = WIDTH / SLICE_W;

  // A stage record carries the operands forward so that later stages find their
  // untouched nibbles, plus every sum nibble resolved so far.
  typedef struct packed {
    stage_ctl_t       ctl;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
  } stage_t;

  stage_t stg_q [NSLICE];
  stage_t stg_d [NSLICE];
  stage_t src   [NSLICE];  // record that stage k consumes this cycle

  logic [SLICE_W-1:0] sl_sum  [NSLICE];
  logic               sl_cout [NSLICE];
  logic               sl_c3   [NSLICE];

  logic             advance;
  logic             ovf_q;
  logic             ovf_d;
  logic             zero_q;
  logic             zero_d;
  logic [WIDTH-1:0] last_sum;

  // The pipeline moves only when the output slot is empty or being drained.
  assign advance  = ~stg_q[NSLICE-1].ctl.valid | out_ready;
  assign in_ready = advance;

  // Stage 0 consumes the conditioned input beat; stage k consumes stage k-1's register.
  always_comb begin
    src[0].ctl.valid = in_valid;
    src[0].ctl.sub   = in_sub;
    // Subtraction is A + ~B + 1, so the caller's carry-in is ignored in that mode.
    src[0].ctl.carry = in_sub | in_cin;
    src[0].a         = in_a;
    src[0].b         = in_sub ? ~in_b : in_b;
    src[0].sum       = '0;
    for (int k = 1; k < NSLICE; k++) begin
      src[k] = stg_q[k-1];
    end
  end

  for (genvar k = 0; k < NSLICE; k++) begin : g_slice
    cla4_slice u_cla (
      .a    (src[k].a[k*SLICE_W +: SLICE_W]),
      .b    (src[k].b[k*SLICE_W +: SLICE_W]),
      .cin  (src[k].ctl.carry),
      .sum  (sl_sum[k]),
      .cout (sl_cout[k]),
      .c3   (sl_c3[k])
    );
  end

  // Next stage state: shift on advance. Payload is captured only for live beats,
  // so a bubble leaves the previous payload in place and outputs keep their last value.
  always_comb begin
    for (int k = 0; k < NSLICE; k++) begin
      stg_d[k] = stg_q[k];
      if (advance) begin
        stg_d[k].ctl.valid = src[k].ctl.valid;
        if (src[k].ctl.valid) begin
          stg_d[k]                              = src[k];
          stg_d[k].ctl.carry                    = sl_cout[k];
          stg_d[k].sum[k*SLICE_W +: SLICE_W]    = sl_sum[k];
        end
      end
    end
  end

  // Flags resolved in the final stage and registered alongside the sum.
  always_comb begin
    last_sum = src[NSLICE-1].sum;
    last_sum[(NSLICE-1)*SLICE_W +: SLICE_W] = sl_sum[NSLICE-1];
    ovf_d  = ovf_q;
    zero_d = zero_q;
    if (advance && src[NSLICE-1].ctl.valid) begin
      ovf_d  = sl_c3[NSLICE-1] ^ sl_cout[NSLICE-1];
      zero_d = (last_sum == '0);
    end
  end

  // Stage and flag registers; reset discards every in-flight beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NSLICE; k++) begin
        stg_q[k] <= '0;
      end
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      for (int k = 0; k < NSLICE; k++) begin
        stg_q[k] <= stg_d[k];
      end
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  assign out_valid = stg_q[NSLICE-1].ctl.valid;
  assign out_sum   = stg_q[NSLICE-1].sum;
  assign out_cout  = stg_q[NSLICE-1].ctl.carry;
  assign out_ovf   = ovf_q;
  assign out_zero  = zero_q;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Purpose: self-checking bench for pipelined_cla_adder at WIDTH=16 and WIDTH=4.
// Latency: checks NSLICE-cycle result latency and in-order delivery.
// Backpressure: exercises global stall via random out_ready.
module tb_pipelined_cla_adder;

  localparam int W  = 16;
  localparam int NS = W / 4;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic          in_cin;
  logic          in_sub;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_sum;
  logic          out_cout;
  logic          out_ovf;
  logic          out_zero;

  logic          n4_in_valid;
  logic          n4_in_ready;
  logic [3:0]    n4_in_a;
  logic [3:0]    n4_in_b;
  logic          n4_in_cin;
  logic          n4_in_sub;
  logic          n4_out_valid;
  logic          n4_out_ready;
  logic [3:0]    n4_out_sum;
  logic          n4_out_cout;
  logic          n4_out_ovf;
  logic          n4_out_zero;

  int n_chk = 0;
  int n_err = 0;

  pipelined_cla_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .out_zero  (out_zero)
  );

  pipelined_cla_adder #(.WIDTH(4)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (n4_in_valid),
    .in_ready  (n4_in_ready),
    .in_a      (n4_in_a),
    .in_b      (n4_in_b),
    .in_cin    (n4_in_cin),
    .in_sub    (n4_in_sub),
    .out_valid (n4_out_valid),
    .out_ready (n4_out_ready),
    .out_sum   (n4_out_sum),
    .out_cout  (n4_out_cout),
    .out_ovf   (n4_out_ovf),
    .out_zero  (n4_out_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
  } vec_t;

  vec_t vecs [13];
  logic [W+2:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Independent reference: plain wide addition, overflow from operand/result signs.
  function automatic logic [W+2:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin, input logic sub);
    logic [W-1:0] be;
    logic [W:0]   full;
    logic         ovf;
    be   = sub ? ~b : b;
    full = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, (sub ? 1'b1 : cin)};
    ovf  = (a[W-1] == be[W-1]) && (full[W-1] != a[W-1]);
    return {full[W-1:0], full[W], ovf, (full[W-1:0] == '0)};
  endfunction

  // One beat through an otherwise empty pipe: checks latency and every output field.
  task automatic run_one(input vec_t v, input string tag);
    in_a = v.a; in_b = v.b; in_cin = v.cin; in_sub = v.sub; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < NS - 1; i++) begin
      chk({tag, "_early_valid"}, 32'(out_valid), 32'd0);
      step();
    end
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_sum"},   32'(out_sum),   32'(v.sum));
    chk({tag, "_cout"},  32'(out_cout),  32'(v.cout));
    chk({tag, "_ovf"},   32'(out_ovf),   32'(v.ovf));
    chk({tag, "_zero"},  32'(out_zero),  32'(v.zero));
  endtask

  // Continuous stream with optional random backpressure, scoreboarded against the model.
  task automatic stream(input int nbeats, input bit rand_rdy, input string tag);
    int           sent;
    int           got;
    int           cycles;
    bit           was_stall;
    logic [31:0]  held;
    logic [W+2:0] e;
    sent = 0; got = 0; cycles = 0; was_stall = 1'b0; held = '0;
    exp_q.delete();
    while (got < nbeats && cycles < 2000) begin
      @(posedge clk);
      #1;
      cycles++;
      in_valid  = (sent < nbeats);
      in_a      = W'($urandom);
      in_b      = W'($urandom);
      in_cin    = 1'($urandom);
      in_sub    = 1'($urandom);
      out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (was_stall)
        chk({tag, "_stall_hold"}, 32'({out_valid, out_sum, out_cout, out_ovf, out_zero}), held);
      if (!rand_rdy)
        chk({tag, "_in_ready_high"}, 32'(in_ready), 32'd1);
      else
        chk({tag, "_in_ready"}, 32'(in_ready), 32'(!(out_valid && !out_ready)));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL %s_extra_result: got sum 0x%0h, expected no result", tag, out_sum);
        end else begin
          e = exp_q.pop_front();
          chk({tag, "_result"}, 32'({out_sum, out_cout, out_ovf, out_zero}), 32'(e));
        end
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_a, in_b, in_cin, in_sub));
        sent++;
      end
      was_stall = out_valid && !out_ready;
      held      = 32'({out_valid, out_sum, out_cout, out_ovf, out_zero});
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk({tag, "_count"}, 32'(got), 32'(nbeats));
    if (!rand_rdy)
      chk({tag, "_cycles"}, 32'(cycles), 32'(nbeats + NS));
  endtask

  initial begin
    vecs[0]  = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[2]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{16'h1234, 16'h1234, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[7]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
    vecs[8]  = '{16'h000F, 16'h0001, 1'b0, 1'b0, 16'h0010, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{16'h0FFF, 16'h0000, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{16'hABCD, 16'h5433, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[12] = '{16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0};

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
    out_ready = 1'b1;
    n4_in_valid = 1'b0; n4_in_a = '0; n4_in_b = '0; n4_in_cin = 1'b0; n4_in_sub = 1'b0;
    n4_out_ready = 1'b1;

    // Reset state
    step();
    step();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_sum",   32'(out_sum),   32'd0);
    chk("rst_cout",  32'(out_cout),  32'd0);
    chk("rst_ovf",   32'(out_ovf),   32'd0);
    chk("rst_zero",  32'(out_zero),  32'd0);
    rst = 1'b0;
    step();
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_n4_valid", 32'(n4_out_valid), 32'd0);

    // Directed vector table
    for (int i = 0; i < 13; i++) begin
      run_one(vecs[i], $sformatf("vec%0d", i));
    end

    // Back-to-back stream, then random backpressure
    stream(64, 1'b0, "b2b");
    stream(48, 1'b1, "stall");

    // Reset with three beats in flight
    step();
    for (int i = 0; i < 3; i++) begin
      in_a = 16'h1111 * 16'(i + 1); in_b = 16'h0F0F; in_cin = 1'b1; in_sub = 1'b0;
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_sum",   32'(out_sum),   32'd0);
    chk("midrst_cout",  32'(out_cout),  32'd0);
    chk("midrst_ovf",   32'(out_ovf),   32'd0);
    chk("midrst_zero",  32'(out_zero),  32'd0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("midrst_no_valid", 32'(out_valid), 32'd0);
    end
    run_one(vecs[2], "after_rst");

    // WIDTH=4 instance: single stage, latency 1
    n4_in_a = 4'h7; n4_in_b = 4'h1; n4_in_cin = 1'b0; n4_in_sub = 1'b0; n4_in_valid = 1'b1;
    step();
    n4_in_a = 4'hF; n4_in_b = 4'h0; n4_in_cin = 1'b1;
    chk("n4_a_valid", 32'(n4_out_valid), 32'd1);
    chk("n4_a_sum",   32'(n4_out_sum),   32'h8);
    chk("n4_a_ovf",   32'(n4_out_ovf),   32'd1);
    chk("n4_a_cout",  32'(n4_out_cout),  32'd0);
    chk("n4_a_zero",  32'(n4_out_zero),  32'd0);
    step();
    n4_in_valid = 1'b0;
    chk("n4_b_valid", 32'(n4_out_valid), 32'd1);
    chk("n4_b_sum",   32'(n4_out_sum),   32'h0);
    chk("n4_b_cout",  32'(n4_out_cout),  32'd1);
    chk("n4_b_zero",  32'(n4_out_zero),  32'd1);
    chk("n4_b_ovf",   32'(n4_out_ovf),   32'd0);
    step();
    chk("n4_drain_valid", 32'(n4_out_valid), 32'd0);
    chk("n4_hold_sum",    32'(n4_out_sum),   32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/pipelined_cla_adder.md
# pipelined_cla_adder

Parametrised, pipelined successor to the team's 4-bit carry-lookahead adder. Splits a WIDTH-bit add/subtract into 4-bit lookahead slices, one slice per pipeline stage, with the carry rippling stage to stage through registers. Accepts one operation per cycle and delivers results with a valid/ready handshake. Adds subtract mode, signed overflow and zero flags. Sits between operand sources and any datapath needing wide arithmetic at high clock rate.

## Interface
- WIDTH, 16: operand width; must be a multiple of 4 and at least 4; NSLICE = WIDTH/4.
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block can accept a beat this cycle.
- in_a  in  WIDTH  operand A (unsigned or two's-complement).
- in_b  in  WIDTH  operand B.
- in_cin  in  1  carry-in; used in add mode only.
- in_sub  in  1  1 = A − B, 0 = A + B + cin.
- out_valid  out  1  result beat present.
- out_ready  in  1  consumer accepts the result this cycle.
- out_sum  out  WIDTH  result bits.
- out_cout  out  1  carry out of the MSB; in subtract mode, 1 = no borrow.
- out_ovf  out  1  signed overflow.
- out_zero  out  1  out_sum == 0.

## Operation
- Subtract: effective B = ~in_b and effective carry-in = 1; in_cin is ignored. Add: effective B = in_b, carry-in = in_cin.
- Stage k (0..NSLICE−1) computes slice k (bits 4k+3:4k) with 4-bit lookahead from the registered carry of stage k−1 (stage 0 uses the effective carry-in). It registers:
  - the sum nibble,
  - the slice carry-out,
  - the untouched upper operand nibbles, skewed forward,
  - all previously computed lower sum nibbles.
- Each stage has a valid bit. A stage holds data only when its valid bit is set.
- advance = ~out_valid | out_ready. All stages shift together when advance = 1 and all hold when advance = 0 (global stall). Bubbles are not squeezed out.
- in_ready = advance. A beat is accepted when in_valid & in_ready.
- Final stage outputs:
  - out_cout = carry out of bit WIDTH−1.
  - out_ovf = carry into MSB XOR carry out of MSB.
  - out_zero is registered alongside the sum.
- Arithmetic is modulo 2^WIDTH; no saturation.

## Timing
- Reset: every valid bit = 0; out_valid = 0; out_sum, out_cout, out_ovf = 0; out_zero = 0. in_ready = 1 in the cycle after reset deasserts.
- Latency: a beat accepted at edge t shows out_valid = 1 after edge t+NSLICE−1, i.e. NSLICE cycles of register delay. Results emerge in acceptance order.
- Throughput: one beat per cycle while out_ready = 1.
- Stall: when out_valid & ~out_ready, every output and every stage register holds its value and in_ready = 0.
- When out_valid = 0, the pipeline advances even if out_ready = 0.
- Accept and retire in the same cycle is legal and is the steady state.
- rst mid-operation: all in-flight beats are discarded with no partial output, and outputs return to their reset values on the next edge.
- Output data is only meaningful while out_valid = 1; it holds its last value otherwise.
- WIDTH = 4: a single stage, latency 1.

## Structure
- Shared package `adder_pkg`: SLICE_W = 4 constant and a stage-record typedef (valid, carry, sum-so-far, remaining A/B, sub flag). Width-dependent types stay local to the module.
- One sub-module, `cla4_slice`: a combinational 4-bit lookahead slice with inputs a[3:0], b[3:0], cin and outputs sum[3:0], cout, and c3 (carry into bit 3, needed for the overflow flag). Instantiate it NSLICE times in a generate loop.

## Test plan
- WIDTH=16, add 0x00FF + 0x0001, cin=0, out_ready=1 → after 4 cycles: sum 0x0100, cout 0, ovf 0, zero 0.
- Add 0xFFFF + 0x0001, cin=0 → sum 0x0000, cout 1, zero 1, ovf 0. Then sub 0x8000 − 0x0001 → sum 0x7FFF, cout 1, ovf 1.
- Back-to-back stream of 64 random beats with out_ready=1 → 64 results in order, one per cycle, matching a reference model; in_ready stays 1 throughout.
- Random out_ready toggling (50%) under continuous in_valid → no beat lost or duplicated; outputs stable while stalled; in_ready = 0 exactly when out_valid & ~out_ready.
- Reset asserted with 3 beats in flight → no out_valid afterwards; outputs at reset values; the next beat returns a correct result after 4 cycles.
- WIDTH=4 build: 0x7 + 0x1 → sum 0x8, ovf 1, latency 1; add 0xF + 0x0 with cin=1 → sum 0x0, cout 1, zero 1.
